// File: rtl/nibble_alu_seq_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
package nibble_alu_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } alu_state_e;

    localparam logic OpAdd = 1'b0;
    localparam logic OpSub = 1'b1;

    // Nibble index width; a single-nibble build still needs a 1-bit counter.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_alu_seq_addsub4_slice.sv
// Combinational 4-bit add/sub slice; c3 is the carry into bit 3 for overflow detection.
module addsub4_slice
    import nibble_alu_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);

    logic [3:0] bx;
    logic [3:0] lo;
    logic [1:0] hi;

    assign bx   = (sub == OpSub) ? ~b : b;
    assign lo   = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
    assign c3   = lo[3];
    assign hi   = {1'b0, a[3]} + {1'b0, bx[3]} + {1'b0, c3};
    assign s    = {hi[0], lo[2:0]};
    assign cout = hi[1];

endmodule

// File: rtl/nibble_alu_seq.sv
// WIDTH-bit add/sub built from one time-shared 4-bit slice, LSB nibble first.
// Optional signed-overflow output "of" is enabled by defining ALU_SEQ_OVF_EN.
module nibble_alu_seq
    import nibble_alu_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] f,
    output logic                 cf,
    output logic                 zf
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic                 of
`endif
);

    localparam int unsigned Width = 4 * NIBBLES;
    localparam int unsigned IdxW  = idx_width(NIBBLES);

    alu_state_e       state_q, state_d;
    logic [Width-1:0] a_q, a_d, b_q, b_d, work_q, work_d, f_q, f_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             sub_q, sub_d, carry_q, carry_d;
    logic             cf_q, cf_d, zf_q, zf_d;

    logic [Width-1:0] a_sh, b_sh;
    logic [3:0]       slice_s;
    logic             slice_cout, slice_c3, last_nib;

    assign a_sh     = a_q >> {idx_q, 2'b00};
    assign b_sh     = b_q >> {idx_q, 2'b00};
    assign last_nib = (idx_q == IdxW'(NIBBLES - 1));

    addsub4_slice u_slice (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .sub  (sub_q),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

`ifdef ALU_SEQ_OVF_EN
    logic of_q, of_d;
    assign of = of_q;
`else
    logic unused_c3;
    assign unused_c3 = slice_c3;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        work_d  = work_q;
        f_d     = f_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
`ifdef ALU_SEQ_OVF_EN
        of_d    = of_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    idx_d   = '0;
                    carry_d = sub;  // +1 of the two's-complement negate
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(NIBBLES); i++) begin
                    if (idx_q == IdxW'(i)) work_d[i*4 +: 4] = slice_s;
                end
                carry_d = slice_cout;
                if (last_nib) begin
                    // Outputs are loaded on entry to DONE so they are valid while done is high.
                    idx_d   = '0;
                    state_d = StDone;
                    f_d     = work_d;
                    cf_d    = slice_cout ^ sub_q;
                    zf_d    = (work_d == '0);
`ifdef ALU_SEQ_OVF_EN
                    of_d    = slice_c3 ^ slice_cout;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            f_q     <= '0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            of_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            f_q     <= f_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
`ifdef ALU_SEQ_OVF_EN
            of_q    <= of_d;
`endif
        end
    end

    assign ready = (state_q == StIdle);
    assign busy  = (state_q == StRun) || (state_q == StDone);
    assign done  = (state_q == StDone);
    assign f     = f_q;
    assign cf    = cf_q;
    assign zf    = zf_q;

endmodule

// File: tb/tb_nibble_alu_seq.sv
// Directed plus random checks of nibble_alu_seq against an arithmetic reference model.
module tb_nibble_alu_seq;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst, start, sub;
    logic [W-1:0] a, b, f;
    logic         ready, busy, done, cf, zf;
`ifdef ALU_SEQ_OVF_EN
    logic         of;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_alu_seq #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .f     (f),
        .cf    (cf),
        .zf    (zf)
`ifdef ALU_SEQ_OVF_EN
        ,
        .of    (of)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {of, cf, f} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        longint ur, sr;
        logic [W-1:0] res;
        logic c, o;
        ur  = s ? (longint'(x) - longint'(y)) : (longint'(x) + longint'(y));
        sr  = s ? (longint'($signed(x)) - longint'($signed(y)))
                : (longint'($signed(x)) + longint'($signed(y)));
        res = ur[W-1:0];
        c   = s ? (x < y) : (ur > longint'((1 << W) - 1));
        o   = (sr > longint'((1 << (W - 1)) - 1)) || (sr < -longint'(1 << (W - 1)));
        return {o, c, res};
    endfunction

    task automatic run_op(input string tag, input logic s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit reissue);
        logic [W+1:0] exp;
        logic [W-1:0] f_prev;
        int cnt, extra_done;
        exp = model(s, x, y);
        @(negedge clk);
        check({tag, ".ready"}, ready, 1);
        start = 1'b1; sub = s; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = W'($urandom()); b = W'($urandom()); sub = 1'($urandom());
        f_prev = f;
        check({tag, ".busy"}, busy, 1);
        cnt = 0;
        while (done !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
            start = (reissue && cnt == 1);
            if (reissue && cnt == 1) a = 16'h1234;
            if (cnt == 2 && done !== 1'b1) check({tag, ".f_hold"}, f, f_prev);
        end
        start = 1'b0;
        check({tag, ".latency"}, cnt, NIBBLES);
        check({tag, ".f"}, f, exp[W-1:0]);
        check({tag, ".cf"}, cf, exp[W]);
        check({tag, ".zf"}, zf, exp[W-1:0] == '0);
`ifdef ALU_SEQ_OVF_EN
        check({tag, ".of"}, of, exp[W+1]);
`endif
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".ready_after"}, ready, 1);
        check({tag, ".f_after"}, f, exp[W-1:0]);
        if (reissue) begin
            extra_done = 0;
            repeat (8) begin
                @(negedge clk);
                if (done === 1'b1 || busy === 1'b1) extra_done++;
            end
            check({tag, ".no_second_op"}, extra_done, 0);
            check({tag, ".f_final"}, f, exp[W-1:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int quiet;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst.ready", ready, 1);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.f", f, 0);
        check("rst.cf", cf, 0);
        check("rst.zf", zf, 0);
        rst = 1'b0;

        run_op("t1_sub_wrap", 1'b1, 16'h0000, 16'h0001, 1'b0);
        run_op("t2_add_carry", 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        run_op("t3_add", 1'b0, 16'h0003, 16'h0001, 1'b0);
        run_op("t3_sub_zero", 1'b1, 16'h0001, 16'h0001, 1'b0);
        run_op("t4_reissue", 1'b0, 16'h0102, 16'h0304, 1'b1);
        run_op("t6_add_ovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0);
        run_op("t6_sub_ovf", 1'b1, 16'h8000, 16'h0001, 1'b0);

        // Reset during the second RUN cycle aborts the op and clears the outputs.
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5.ready", ready, 1);
        check("t5.busy", busy, 0);
        check("t5.done", done, 0);
        check("t5.f", f, 0);
        check("t5.cf", cf, 0);
        check("t5.zf", zf, 0);
`ifdef ALU_SEQ_OVF_EN
        check("t5.of", of, 0);
`endif
        quiet = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) quiet++;
        end
        check("t5.no_done", quiet, 0);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 1'($urandom()), W'($urandom()), W'($urandom()), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
